// File: rtl/fetch_if.sv
// Program-memory read bus between the fetch stage (master) and instruction memory (slave).
interface fetch_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_rd;
    logic [INSTR_W-1:0] mem_data;
    logic               mem_ack;

    modport master (output mem_addr, output mem_rd, input mem_data, input mem_ack);
    modport slave  (input mem_addr, input mem_rd, output mem_data, output mem_ack);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC and IR, reads one word per fetch request over a req/ack bus.
//
// state | meaning
// IDLE  | no read outstanding; accepts fetch_start or a direct PC jump
// WAIT  | read outstanding on the bus; jumps are held as a pending target
module fetch_unit #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_start,
    input  logic               jump_load,
    input  logic [ADDR_W-1:0]  jump_target,
    fetch_if.master            mem,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] ir,
    output logic [4:0]         opcode,
    output logic               ir_valid,
    output logic               busy
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_q;
    logic              pend;
    logic [ADDR_W-1:0] pend_target;

    assign mem.mem_addr = addr_q;
    assign mem.mem_rd   = rd_q;
    assign opcode       = ir[15:11];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            ir          <= '0;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            ir_valid    <= 1'b0;
            busy        <= 1'b0;
            pend        <= 1'b0;
            pend_target <= '0;
        end else begin
            ir_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (fetch_start) begin
                        addr_q <= jump_load ? jump_target : pc;
                        rd_q   <= 1'b1;
                        busy   <= 1'b1;
                        state  <= WAIT;
                    end else if (jump_load) begin
                        pc <= jump_target;
                    end
                end
                WAIT: begin
                    if (mem.mem_ack) begin
                        ir       <= mem.mem_data;
                        ir_valid <= 1'b1;
                        rd_q     <= 1'b0;
                        busy     <= 1'b0;
                        pend     <= 1'b0;
                        state    <= IDLE;
                        // a jump arriving with the ack beats any earlier pending one
                        if (jump_load)
                            pc <= jump_target;
                        else if (pend)
                            pc <= pend_target;
                        else
                            pc <= addr_q + 1'b1;
                    end else if (jump_load) begin
                        pend        <= 1'b1;
                        pend_target <= jump_target;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the microcoded control unit. Owns the program counter (PC) and instruction register (IR). On a fetch request it reads one instruction word from program memory over a req/ack handshake, latches it into the IR, and advances the PC. It exposes `ir[15:11]` as the opcode the control unit decodes, and accepts jump targets from the datapath.

## Interface

Parameters:
- `ADDR_W`, default 8: PC and program-memory address width.
- `INSTR_W`, default 16: instruction word width; must be ≥ 16.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `fetch_start`, input, 1: one-cycle request to fetch the instruction at PC (driven by the control-unit fetch microinstruction).
- `jump_load`, input, 1: load `jump_target` into PC.
- `jump_target`, input, `ADDR_W`: new PC value.
- `mem_addr`, output, `ADDR_W`: program-memory address (registered).
- `mem_rd`, output, 1: read request; held until acknowledged.
- `mem_data`, input, `INSTR_W`: read data, valid when `mem_ack`=1.
- `mem_ack`, input, 1: read complete.
- `pc`, output, `ADDR_W`: current program counter.
- `ir`, output, `INSTR_W`: instruction register.
- `opcode`, output, 5: combinational `ir[15:11]`.
- `ir_valid`, output, 1: one-cycle pulse when the IR was just updated.
- `busy`, output, 1: high while a fetch is in flight.

## Operation

- States: IDLE, WAIT.
- IDLE + `fetch_start`=1:
  - `mem_addr` ← fetch address; `mem_rd` ← 1; `busy` ← 1; go to WAIT.
  - Fetch address is `jump_target` if `jump_load`=1 in the same cycle, else `pc`.
- IDLE + `jump_load`=1 with no `fetch_start`: `pc` ← `jump_target`.
- WAIT + `mem_ack`=0: hold `mem_rd`=1 and `mem_addr` stable. There is no timeout.
- WAIT + `mem_ack`=1:
  - `ir` ← `mem_data`; `ir_valid` ← 1 for one cycle; `mem_rd` ← 0; `busy` ← 0; return to IDLE.
  - `pc` ← `mem_addr`+1 (mod 2^`ADDR_W`), unless a jump is pending; in that case `pc` ← pending target and the pending flag clears.
- WAIT + `jump_load`=1:
  - Records `jump_target` as pending. A later `jump_load` in the same WAIT overwrites it (last wins).
  - If it coincides with `mem_ack`, the target applies immediately as the pending target.
- WAIT + `fetch_start`: ignored, no queuing.
- PC arithmetic is unsigned, `ADDR_W` bits, and wraps from 2^`ADDR_W`−1 to 0 silently.
- `mem_ack` while in IDLE is ignored: IR and PC are unchanged and `ir_valid` stays 0.

## Timing

- Reset values: `pc`=0, `ir`=0, `mem_addr`=0, `mem_rd`=0, `ir_valid`=0, `busy`=0, pending flag=0, state=IDLE. Therefore `opcode`=0 after reset.
- `rst` has priority over every other input, including mid-WAIT. An in-flight fetch is abandoned; a late `mem_ack` after reset is ignored.
- Latency, with `fetch_start` at cycle N:
  - `mem_rd`=1 from cycle N+1.
  - If `mem_ack`=1 in cycle N+k (k≥1), then `ir`, `pc` and `ir_valid`=1 are visible in N+k+1, and `mem_rd`=0 in N+k+1.
  - Minimum fetch-to-IR latency is 2 cycles.
- A new `fetch_start` is accepted in the same cycle `ir_valid` is high. Back-to-back fetches sustain one instruction per 2 cycles with zero-wait memory.
- `jump_load` in IDLE: `pc` updates in the next cycle.

## Test plan

- Reset/basic fetch:
  - Stimulus: assert `rst`, release it; memory[0]=16'h3A05 with ack after 1 cycle; pulse `fetch_start`.
  - Required: `mem_rd`=1 with `mem_addr`=0; then `ir`=16'h3A05, `opcode`=5'b00111, `pc`=1, `ir_valid` high for exactly one cycle.
- Wait states:
  - Stimulus: `mem_ack` delayed 4 cycles.
  - Required: `mem_rd` and `mem_addr` stay stable and `busy`=1 throughout; IR updates only the cycle after ack; a `fetch_start` pulsed during WAIT is ignored (exactly one memory read).
- Jump in IDLE, and jump coincident with fetch:
  - Stimulus: `jump_load`, `jump_target`=8'h40 alone.
  - Required: `pc`=8'h40.
  - Stimulus: `jump_load`=1 with `jump_target`=8'h10 in the same cycle as `fetch_start`.
  - Required: `mem_addr`=8'h10; `pc`=8'h11 after ack.
- Jump during WAIT:
  - Stimulus: fetch at pc=5; `jump_load` with 8'h20, then 8'h30, both before ack.
  - Required: `ir` = memory[5]; `pc`=8'h30 after ack (last wins); the next fetch reads address 8'h30.
- Wrap-around:
  - Stimulus: jump to 8'hFF; fetch.
  - Required: `mem_addr`=8'hFF; `pc`=8'h00 after ack.
- Reset mid-fetch and spurious ack:
  - Stimulus: assert `rst` during WAIT, then pulse `mem_ack` after reset.
  - Required: all outputs at reset values, state IDLE, IR and PC unchanged by the late ack, `ir_valid`=0.
